tff_count_ctrl: RTL and testbench
=================================

// Module: tff_count_ctrl
// PURPOSE
//  Sequencer for a bank of W synchronous toggle flip-flops used as a counter.
//  Each cycle it computes the per-stage toggle vector T[W-1:0]. This gives
//  start/pause/clear control, up or down counting, a programmable limit,
//  and one-shot or free-running operation. Sits between front-panel/FSM
//  control logic and the toggle-flop datapath. Count is visible on the
//  display/LED path.
// PARAMETERS
//  W        4   counter width = number of toggle stages (2..16)
// PORTS
//  clk1      in   1  system clock; all state changes on rising edge
//  s_reset   in   1  synchronous reset, active-low; sampled on clk1 rise
//  start     in   1  1-cycle pulse: begin a count run
//  pause     in   1  level: hold count while 1 (RUN<->PAUSE)
//  clear     in   1  1-cycle pulse: abort run, count<=0, go IDLE
//  up_dn     in   1  1=count up 0..limit, 0=count down limit..0; sampled at start
//  cont      in   1  1=free-running (wrap), 0=one-shot; sampled at start
//  limit     in   W  terminal value; sampled at start
//  count     out  W  current toggle-bank state (Q vector)
//  busy      out  1  1 in RUN or PAUSE
//  done      out  1  1-cycle pulse when one-shot run reaches its terminal value
//  wrap      out  1  1-cycle pulse on each free-running wrap
// BEHAVIOUR
//  Reset (s_reset==0 at edge): state=IDLE, count=0, busy=0, done=0, wrap=0.
//    Latched up_dn/cont/limit reset to 1/0/0. Reset overrides all inputs.
//  count changes only through the bank: Q[i] <= Q[i] ^ T[i]. The controller
//    never writes Q directly. To load value V it drives T = Q ^ V.
//  FSM states: IDLE, RUN, PAUSE, DONE.
//    IDLE : start=1 -> latch up_dn/cont/limit. Load start value in the same
//           edge: 0 if up, limit if down. Go to RUN.
//    RUN  : pause=1 -> PAUSE with T=0. Otherwise step by one:
//           up   T[i] = &Q[i-1:0] (T[0]=1)
//           down T[i] = ~|Q[i-1:0] (T[0]=1)
//           Terminal value is limit (up) or 0 (down), checked on current Q:
//             one-shot -> T=0, done=1 next cycle, go to DONE.
//             cont     -> load start value, wrap=1 next cycle, stay in RUN.
//    PAUSE: T=0. pause=0 -> RUN, resuming on the following cycle.
//    DONE : T=0, count holds terminal value. start -> reload and go to RUN,
//           same as IDLE.
//  clear (any state): T = Q (count->0), state->IDLE, no done/wrap pulse.
//  Priority: s_reset > clear > start > pause > step.
//    start while busy is ignored.
//  limit==0 edge case: the run is terminal on its first RUN cycle.
//    One-shot gives done 2 cycles after start. Cont gives wrap every cycle.
//  Latency: start edge N -> count=start value after N. First step lands
//    after N+1. done/wrap are asserted the cycle after the terminal value
//    is seen.
//  Width: all arithmetic is modulo 2^W. limit is compared bitwise and
//    unsigned. Overflow past 2^W-1 cannot occur because terminal <= 2^W-1.
//  busy = (state==RUN || state==PAUSE), registered alongside the state.
// STRUCTURE
//  Shared package tff_ctrl_pkg: state encoding (IDLE=2'b00, RUN=2'b01,
//    PAUSE=2'b10, DONE=2'b11) and the UP/DOWN direction constants.
//  One sub-module, tff_bank #(W): W toggle stages, each with T input,
//    clk1, and active-low sync reset; outputs the Q vector.
//  Controller: FSM register, latched config, combinational T generator,
//    and registered done/wrap pulses.
// TESTING
//  1. Reset: hold s_reset=0 for 3 cycles with start=1 -> count=0, busy=0,
//     done=0, wrap=0, state IDLE.
//  2. W=4, up, one-shot, limit=5: start -> count 0,1,2,3,4,5. done pulses
//     once 1 cycle after 5. count holds 5, busy=0.
//  3. Down, cont, limit=3: count sequence 3,2,1,0,3,2,... with wrap=1
//     exactly the cycle after each 0, for 3 wraps.
//  4. Up, limit=15: pause high for 4 cycles at count=7 -> count holds 7.
//     Resumes at 8 after release. Full 0..15 reached with no overflow.
//  5. Up, limit=9, clear at count=6 -> next cycle count=0, IDLE, no done.
//     A start pulse during RUN is ignored (count unaffected).
//  6. s_reset=0 mid-run at count=4 -> count=0, IDLE, busy=0, no pulses.
//     limit=0 one-shot -> done 2 cycles after start.

Source files
------------

// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the toggle-flop counter sequencer: FSM state
// encoding and counting-direction constants.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_bank.sv
// Bank of W synchronous toggle flip-flops; each stage flips when its T bit
// is set and clears on the active-low synchronous reset.
module tff_bank #(
  parameter int W = 4
) (
  input  logic         clk1,
  input  logic         s_reset,
  input  logic [W-1:0] t,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  for (genvar i = 0; i < W; i++) begin : g_stage
    always_ff @(posedge clk1) begin
      if (!s_reset) begin
        q_q[i] <= 1'b0;
      end else begin
        q_q[i] <= q_d[i];
      end
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer for a toggle-flop counter: decides each cycle which stages of the
// bank toggle to step, load, hold or clear the count.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk1,
  input  logic         s_reset,
  input  logic         start,
  input  logic         pause,
  input  logic         clear,
  input  logic         up_dn,
  input  logic         cont,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         wrap
);

  state_e       state_q, state_d;
  logic         up_q, up_d;
  logic         cont_q, cont_d;
  logic [W-1:0] limit_q, limit_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         wrap_q, wrap_d;

  logic [W-1:0] q;
  logic [W-1:0] t;
  logic [W-1:0] step_t;
  logic [W-1:0] run_start_val;
  logic [W-1:0] new_start_val;
  logic [W-1:0] term_val;
  logic         at_term;

  tff_bank #(.W(W)) u_bank (
    .clk1    (clk1),
    .s_reset (s_reset),
    .t       (t),
    .q       (q)
  );

  // Single-step toggles: up flips bit i when all lower bits are 1, down when
  // all lower bits are 0.
  always_comb begin : step_gen
    logic ones_below;
    logic zeros_below;
    step_t      = '0;
    ones_below  = 1'b1;
    zeros_below = 1'b1;
    for (int i = 0; i < W; i++) begin
      step_t[i]   = (up_q == DIR_UP) ? ones_below : zeros_below;
      ones_below  = ones_below & q[i];
      zeros_below = zeros_below & ~q[i];
    end
  end

  always_comb begin
    run_start_val = (up_q == DIR_DOWN) ? limit_q : '0;
    new_start_val = (up_dn == DIR_DOWN) ? limit : '0;
    term_val      = (up_q == DIR_UP) ? limit_q : '0;
    at_term       = (q == term_val);
  end

  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    cont_d  = cont_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    t       = '0;

    if (clear) begin
      t       = q;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            up_d    = up_dn;
            cont_d  = cont;
            limit_d = limit;
            t       = q ^ new_start_val;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (at_term) begin
            if (cont_q) begin
              t      = q ^ run_start_val;
              wrap_d = 1'b1;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            t = step_t;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk1) begin
    if (!s_reset) begin
      state_q <= ST_IDLE;
      up_q    <= DIR_UP;
      cont_q  <= 1'b0;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      cont_q  <= cont_d;
      limit_q <= limit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Self-checking bench for tff_count_ctrl (W=4): a vector table for reset and
// a one-shot run, then directed sequences for wrap, pause, clear and limit=0.
module tb_tff_count_ctrl;

  logic       clk1;
  logic       s_reset;
  logic       start;
  logic       pause;
  logic       clear;
  logic       up_dn;
  logic       cont;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       wrap;

  int total;
  int bad;

  typedef struct {
    logic       rst_n;
    logic       st;
    logic       pa;
    logic       cl;
    logic       ud;
    logic       co;
    logic [3:0] lim;
    logic [3:0] exp_count;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[13];

  tff_count_ctrl #(.W(4)) dut (
    .clk1    (clk1),
    .s_reset (s_reset),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .up_dn   (up_dn),
    .cont    (cont),
    .limit   (limit),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  task automatic applyStimulus(input logic rn, input logic st, input logic pa,
                               input logic cl, input logic ud, input logic co,
                               input logic [3:0] lim);
    s_reset = rn;
    start   = st;
    pause   = pa;
    clear   = cl;
    up_dn   = ud;
    cont    = co;
    limit   = lim;
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ec,
                             input logic eb, input logic ed, input logic ew);
    total++;
    if (count !== ec || busy !== eb || done !== ed || wrap !== ew) begin
      bad++;
      $display("[TB] FAIL %s: got count=%0d busy=%b done=%b wrap=%b, expected count=%0d busy=%b done=%b wrap=%b",
               tag, count, busy, done, wrap, ec, eb, ed, ew);
    end
  endtask

  task automatic idleStep(input string tag, input logic [3:0] ec,
                          input logic eb, input logic ed, input logic ew);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput(tag, ec, eb, ed, ew);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd4, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].st, vecs[i].pa, vecs[i].cl,
                    vecs[i].ud, vecs[i].co, vecs[i].lim);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy,
                  vecs[i].exp_done, vecs[i].exp_wrap);
    end

    $display("[TB] down free-running run, limit=3");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
    tick();
    checkOutput("cont_load", 4'd3, 1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      for (int k = 2; k >= 0; k--) begin
        idleStep($sformatf("cont_w%0d_c%0d", w, k), 4'(k), 1'b1, 1'b0, 1'b0);
      end
      idleStep($sformatf("cont_wrap%0d", w), 4'd3, 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("cont_clear", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] up one-shot limit=15 with pause at 7");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
    tick();
    checkOutput("p_load", 4'd0, 1'b1, 1'b0, 1'b0);
    for (int v = 1; v <= 7; v++) begin
      idleStep($sformatf("p_up%0d", v), 4'(v), 1'b1, 1'b0, 1'b0);
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      checkOutput($sformatf("p_hold%0d", c), 4'd7, 1'b1, 1'b0, 1'b0);
    end
    idleStep("p_release", 4'd7, 1'b1, 1'b0, 1'b0);
    for (int v = 8; v <= 15; v++) begin
      idleStep($sformatf("p_up%0d", v), 4'(v), 1'b1, 1'b0, 1'b0);
    end
    idleStep("p_done", 4'd15, 1'b0, 1'b1, 1'b0);
    idleStep("p_hold15", 4'd15, 1'b0, 1'b0, 1'b0);

    $display("[TB] up limit=9, ignored start, clear at 6");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    tick();
    checkOutput("c_load", 4'd0, 1'b1, 1'b0, 1'b0);
    for (int v = 1; v <= 3; v++) begin
      idleStep($sformatf("c_up%0d", v), 4'(v), 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("c_start_ignored", 4'd4, 1'b1, 1'b0, 1'b0);
    idleStep("c_up5", 4'd5, 1'b1, 1'b0, 1'b0);
    idleStep("c_up6", 4'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("c_clear", 4'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      idleStep($sformatf("c_idle%0d", c), 4'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] reset mid-run and limit=0 runs");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    tick();
    checkOutput("r_load", 4'd0, 1'b1, 1'b0, 1'b0);
    for (int v = 1; v <= 4; v++) begin
      idleStep($sformatf("r_up%0d", v), 4'(v), 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    tick();
    checkOutput("r_reset", 4'd0, 1'b0, 1'b0, 1'b0);
    idleStep("r_idle0", 4'd0, 1'b0, 1'b0, 1'b0);
    idleStep("r_idle1", 4'd0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    checkOutput("z1_load", 4'd0, 1'b1, 1'b0, 1'b0);
    idleStep("z1_done", 4'd0, 1'b0, 1'b1, 1'b0);
    idleStep("z1_after", 4'd0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    tick();
    checkOutput("z0_load", 4'd0, 1'b1, 1'b0, 1'b0);
    idleStep("z0_wrap0", 4'd0, 1'b1, 1'b0, 1'b1);
    idleStep("z0_wrap1", 4'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("z0_clear", 4'd0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    tick();
    checkOutput("d_load", 4'd2, 1'b1, 1'b0, 1'b0);
    idleStep("d_dn1", 4'd1, 1'b1, 1'b0, 1'b0);
    idleStep("d_dn0", 4'd0, 1'b1, 1'b0, 1'b0);
    idleStep("d_done", 4'd0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
